// File: rtl/ext_domain_power_seq.sv
`default_nettype none
// ============================================================================
// Module   : ext_domain_power_seq
// Purpose  : Power sequencer for one gated external subsystem domain. Drives
//            the power switch, isolation and domain reset in order, waits for
//            the switch-cell acknowledge, and flags ack timeouts/losses.
// Ports    : clk_i, rst_ni         - clock, asynchronous active-low reset
//            pwr_on_i              - target level, 1 = domain powered
//            switch_ack_i          - asynchronous ack from the switch cells
//            err_clr_i             - one-cycle pulse clearing err_o
//            switch_o/iso_o/rst_no - switch, isolation, domain reset (low)
//            busy_o                - high in every state except OFF and ON
//            state_o               - current state encoding
//            err_o                 - sticky error flag
// Revision : 1.0 - initial release
// ============================================================================
module ext_domain_power_seq #(
  parameter int ISO_CYCLES  = 4,
  parameter int RST_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pwr_on_i,
  input  logic       switch_ack_i,
  input  logic       err_clr_i,
  output logic       switch_o,
  output logic       iso_o,
  output logic       rst_no,
  output logic       busy_o,
  output logic [2:0] state_o,
  output logic       err_o
);

  localparam int c_max_dwell = (ISO_CYCLES > RST_CYCLES) ? ISO_CYCLES : RST_CYCLES;
  localparam int c_max_all   = (c_max_dwell > ACK_TIMEOUT) ? c_max_dwell : ACK_TIMEOUT;
  localparam int c_cnt_w     = $clog2(c_max_all) + 1;

  localparam logic [c_cnt_w-1:0] c_iso_last = c_cnt_w'(ISO_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_ack_last = c_cnt_w'(ACK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_sat  = '1;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_SW_ON    = 3'd1,
    S_RST_WAIT = 3'd2,
    S_ISO_REL  = 3'd3,
    S_ON       = 3'd4,
    S_ISO_SET  = 3'd5,
    S_SW_OFF   = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 ack_s;
  logic                 err_set;
  logic                 switch_q, iso_q, rst_n_q, busy_q, err_q;

  // ---------------------------------------------------------------------------
  // Ack synchronizer
  // ---------------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= switch_ack_i;
      end
    end else begin : g_sync_chain
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], switch_ack_i};
      end
    end
  endgenerate

  assign ack_s = sync_q[SYNC_STAGES-1];

  // {switch, iso, rst_n} for each state
  function automatic logic [2:0] out_dec(input state_e s);
    case (s)
      S_SW_ON, S_RST_WAIT: out_dec = 3'b110;
      S_ISO_REL, S_ISO_SET: out_dec = 3'b111;
      S_ON:                out_dec = 3'b101;
      default:             out_dec = 3'b010; // OFF, SW_OFF and unused codes
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and error-set decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      S_OFF: begin
        if (pwr_on_i) state_d = S_SW_ON;
      end
      S_SW_ON: begin
        // An ack arriving on the timeout cycle takes priority.
        if (ack_s) begin
          state_d = S_RST_WAIT;
        end else if (cnt_q == c_ack_last) begin
          state_d = S_SW_OFF;
          err_set = 1'b1;
        end
      end
      S_RST_WAIT: begin
        if (!ack_s) err_set = 1'b1;
        if (cnt_q == c_rst_last) state_d = S_ISO_REL;
      end
      S_ISO_REL: begin
        if (!ack_s) err_set = 1'b1;
        if (cnt_q == c_iso_last) state_d = S_ON;
      end
      S_ON: begin
        if (!ack_s) err_set = 1'b1;
        if (!pwr_on_i) state_d = S_ISO_SET;
      end
      S_ISO_SET: begin
        if (!ack_s) err_set = 1'b1;
        if (cnt_q == c_iso_last) state_d = S_SW_OFF;
      end
      S_SW_OFF: begin
        if (!ack_s) begin
          state_d = S_OFF;
        end else if (cnt_q == c_ack_last) begin
          state_d = S_OFF;
          err_set = 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, dwell counter and registered outputs. Outputs are loaded from the
  // next state so they line up with state_q without a decode stage after it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      switch_q <= 1'b0;
      iso_q    <= 1'b1;
      rst_n_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != c_cnt_sat) begin
        cnt_q <= cnt_q + 1'b1;
      end
      {switch_q, iso_q, rst_n_q} <= out_dec(state_d);
      busy_q <= (state_d != S_OFF) && (state_d != S_ON);
      if (err_set)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  assign switch_o = switch_q;
  assign iso_o    = iso_q;
  assign rst_no   = rst_n_q;
  assign busy_o   = busy_q;
  assign state_o  = state_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire
